// File: rtl/cache.sv
// cache: LLC tag/MESI/4-way tree-PLRU model; define CACHE_STATS_EN for saturating access counters.
module cache #(
   parameter int SETS       = 64,
   parameter int WAYS       = 4,
   parameter int LINE_BYTES = 64,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   input  logic [3:0]        command,
   input  logic [ADDR_W-1:0] address,
   input  logic [1:0]        snoop_in,
   output logic              resp_valid,
   output logic              hit,
   output logic              miss,
   output logic [2:0]        bus_op,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [1:0]        snoop_resp,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [3:0]        l1_msg,
   output logic              err
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]       stat_reads,
   output logic [31:0]       stat_writes,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses
`endif
);
   localparam int IW = $clog2(SETS);
   localparam int OW = $clog2(LINE_BYTES);
   localparam int TW = ADDR_W - IW - OW;
   localparam logic [2:0] BUS_READ = 3'd1, BUS_WRITE = 3'd2, BUS_INV = 3'd3, BUS_RWIM = 3'd4;
   localparam logic [1:0] SR_HIT = 2'd0, SR_HITM = 2'd1, SR_NOHIT = 2'd2;
   localparam logic [3:0] L1_EVICT = 4'b1000, L1_INV = 4'b0100, L1_SEND = 4'b0010, L1_GET = 4'b0001;
   typedef enum logic [1:0] {ST_I, ST_S, ST_E, ST_M} mesi_e;

   logic [TW-1:0] tag_q [SETS][WAYS];
   mesi_e         st_q  [SETS][WAYS];
   logic [2:0]    plru_q[SETS];

   logic              resp_valid_q, hit_q, miss_q, wb_valid_q, err_q;
   logic              resp_valid_d, hit_d, miss_d, wb_valid_d, err_d;
   logic [2:0]        bus_op_q, bus_op_d;
   logic [1:0]        snoop_resp_q, snoop_resp_d;
   logic [3:0]        l1_msg_q, l1_msg_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d, wb_addr_q, wb_addr_d, line_addr;

   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic [1:0]    hit_way, inv_way, victim, fill_way, acc_way, wr_way;
   logic [2:0]    plru, plru_upd;
   logic          lookup_hit, has_inv, wr_en, plru_wr, flush, evict;
   mesi_e         cur_st, wr_st;
   logic          unused_bits;

   assign idx         = address[OW+IW-1:OW];
   assign tag         = address[ADDR_W-1:OW+IW];
   assign line_addr   = {address[ADDR_W-1:OW], {OW{1'b0}}};
   assign unused_bits = ^{address[OW-1:0], snoop_in[0]};

   always_comb begin
      lookup_hit = 1'b0;
      hit_way    = '0;
      has_inv    = 1'b0;
      inv_way    = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (st_q[idx][w] != ST_I && tag_q[idx][w] == tag) begin
            lookup_hit = 1'b1;
            hit_way    = 2'(w);
         end
         if (st_q[idx][w] == ST_I) begin
            has_inv = 1'b1;
            inv_way = 2'(w);
         end
      end
   end

   // Tree bits {b2,b1,b0}: b0 picks the half, b1/b2 pick within it.
   assign plru     = plru_q[idx];
   assign victim   = {plru[0], plru[0] ? plru[2] : plru[1]};
   assign fill_way = has_inv ? inv_way : victim;
   assign acc_way  = lookup_hit ? hit_way : fill_way;
   assign plru_upd = acc_way[1] ? {acc_way == 2'd2, plru[1], 1'b0} : {plru[2], acc_way == 2'd0, 1'b1};
   assign cur_st   = lookup_hit ? st_q[idx][hit_way] : ST_I;

   always_comb begin
      resp_valid_d = cmd_valid;
      hit_d        = 1'b0;
      miss_d       = 1'b0;
      bus_op_d     = '0;
      bus_addr_d   = bus_addr_q;
      snoop_resp_d = '0;
      wb_valid_d   = 1'b0;
      wb_addr_d    = wb_addr_q;
      l1_msg_d     = '0;
      err_d        = 1'b0;
      wr_en        = 1'b0;
      wr_way       = hit_way;
      wr_st        = ST_I;
      plru_wr      = 1'b0;
      flush        = 1'b0;
      evict        = 1'b0;
      if (cmd_valid) begin
         case (command)
            4'd0, 4'd1, 4'd2: begin
               hit_d    = lookup_hit;
               miss_d   = !lookup_hit;
               l1_msg_d = command == 4'd1 ? L1_GET : L1_SEND;
               plru_wr  = 1'b1;
               wr_en    = command == 4'd1 || !lookup_hit;
               wr_way   = acc_way;
               evict    = !lookup_hit && !has_inv;
               wr_st    = command == 4'd1 ? ST_M : (snoop_in[1] ? ST_E : ST_S);
               bus_op_d = lookup_hit ? (command == 4'd1 && cur_st == ST_S ? BUS_INV : 3'd0)
                                     : (command == 4'd1 ? BUS_RWIM : BUS_READ);
               bus_addr_d = bus_op_d != 3'd0 ? line_addr : bus_addr_q;
            end
            4'd3, 4'd5: begin
               snoop_resp_d = cur_st == ST_I ? SR_NOHIT : (cur_st == ST_M ? SR_HITM : SR_HIT);
               bus_op_d     = cur_st == ST_M ? BUS_WRITE : 3'd0;
               bus_addr_d   = cur_st == ST_M ? line_addr : bus_addr_q;
               l1_msg_d     = (cur_st == ST_M ? L1_GET : 4'd0) |
                              (command == 4'd5 && cur_st != ST_I ? L1_INV : 4'd0);
               wr_en        = cur_st != ST_I;
               wr_st        = command == 4'd3 ? ST_S : ST_I;
            end
            4'd4: snoop_resp_d = SR_NOHIT;
            4'd6: begin
               snoop_resp_d = cur_st == ST_S ? SR_HIT : SR_NOHIT;
               l1_msg_d     = cur_st == ST_S ? L1_INV : 4'd0;
               wr_en        = cur_st == ST_S;
               wr_st        = ST_I;
            end
            4'd8: begin
               flush      = 1'b1;
               bus_addr_d = '0;
               wb_addr_d  = '0;
            end
            4'd9: ;
            default: err_d = 1'b1;
         endcase
      end
      if (evict) begin
         l1_msg_d   = l1_msg_d | L1_EVICT;
         wb_valid_d = st_q[idx][victim] == ST_M;
         wb_addr_d  = st_q[idx][victim] == ST_M ? {tag_q[idx][victim], idx, {OW{1'b0}}} : wb_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         bus_op_q     <= '0;
         bus_addr_q   <= '0;
         snoop_resp_q <= '0;
         wb_valid_q   <= 1'b0;
         wb_addr_q    <= '0;
         l1_msg_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         resp_valid_q <= resp_valid_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         bus_op_q     <= bus_op_d;
         bus_addr_q   <= bus_addr_d;
         snoop_resp_q <= snoop_resp_d;
         wb_valid_q   <= wb_valid_d;
         wb_addr_q    <= wb_addr_d;
         l1_msg_q     <= l1_msg_d;
         err_q        <= err_d;
      end
      if (!rst_n || flush) begin
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) st_q[s][w] <= ST_I;
         end
      end else begin
         if (wr_en) begin
            st_q[idx][wr_way]  <= wr_st;
            tag_q[idx][wr_way] <= tag;
         end
         if (plru_wr) plru_q[idx] <= plru_upd;
      end
   end

   assign resp_valid = resp_valid_q;
   assign hit        = hit_q;
   assign miss       = miss_q;
   assign bus_op     = bus_op_q;
   assign bus_addr   = bus_addr_q;
   assign snoop_resp = snoop_resp_q;
   assign wb_valid   = wb_valid_q;
   assign wb_addr    = wb_addr_q;
   assign l1_msg     = l1_msg_q;
   assign err        = err_q;

`ifdef CACHE_STATS_EN
   logic [31:0] reads_q, writes_q, hits_q, misses_q, reads_d, writes_d, hits_d, misses_d;
   always_comb begin
      reads_d  = flush ? '0 : reads_q  + 32'(cmd_valid && (command == 4'd0 || command == 4'd2) && ~&reads_q);
      writes_d = flush ? '0 : writes_q + 32'(cmd_valid && command == 4'd1 && ~&writes_q);
      hits_d   = flush ? '0 : hits_q   + 32'(hit_d && ~&hits_q);
      misses_d = flush ? '0 : misses_q + 32'(miss_d && ~&misses_q);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reads_q  <= '0;
         writes_q <= '0;
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         reads_q  <= reads_d;
         writes_q <= writes_d;
         hits_q   <= hits_d;
         misses_q <= misses_d;
      end
   end
   assign stat_reads  = reads_q;
   assign stat_writes = writes_q;
   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`endif
endmodule

// File: tb/tb_cache.sv
// tb_cache: directed plus randomized checks of the cache against a line-level MESI/PLRU reference model.
module tb_cache;
   logic        clk, rst_n, cmd_valid;
   logic [3:0]  command;
   logic [31:0] address;
   logic [1:0]  snoop_in;
   logic        resp_valid, hit, miss, wb_valid, err;
   logic [2:0]  bus_op;
   logic [31:0] bus_addr, wb_addr;
   logic [1:0]  snoop_resp;
   logic [3:0]  l1_msg;

   int checks = 0;
   int errors = 0;

   // Reference state: MESI as 0=I 1=S 2=E 3=M, tree bits kept per set.
   int          m_st [64][4];
   logic [19:0] m_tag[64][4];
   bit          b0[64], b1[64], b2[64];
   logic        e_rv, e_hit, e_miss, e_wb, e_err;
   logic [2:0]  e_op;
   logic [1:0]  e_sr;
   logic [3:0]  e_l1;
   logic [31:0] e_baddr, e_wbaddr;

   cache dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .command(command), .address(address),
      .snoop_in(snoop_in), .resp_valid(resp_valid), .hit(hit), .miss(miss), .bus_op(bus_op),
      .bus_addr(bus_addr), .snoop_resp(snoop_resp), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .l1_msg(l1_msg), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < 64; s++) begin
         b0[s] = 0; b1[s] = 0; b2[s] = 0;
         for (int w = 0; w < 4; w++) m_st[s][w] = 0;
      end
   endtask

   task automatic touch(input int s, input int w);
      if (w < 2) begin b0[s] = 1; b1[s] = (w == 0); end
      else begin b0[s] = 0; b2[s] = (w == 2); end
   endtask

   task automatic check_all(input string t);
      chk({t, ".resp_valid"}, 32'(resp_valid), 32'(e_rv));
      chk({t, ".hit"}, 32'(hit), 32'(e_hit));
      chk({t, ".miss"}, 32'(miss), 32'(e_miss));
      chk({t, ".bus_op"}, 32'(bus_op), 32'(e_op));
      chk({t, ".bus_addr"}, bus_addr, e_baddr);
      chk({t, ".snoop_resp"}, 32'(snoop_resp), 32'(e_sr));
      chk({t, ".wb_valid"}, 32'(wb_valid), 32'(e_wb));
      chk({t, ".wb_addr"}, wb_addr, e_wbaddr);
      chk({t, ".l1_msg"}, 32'(l1_msg), 32'(e_l1));
      chk({t, ".err"}, 32'(err), 32'(e_err));
   endtask

   task automatic step(input logic [3:0] c, input logic [31:0] a, input logic [1:0] s);
      int idx, hw, w;
      logic [31:0] line;
      idx  = int'(a[11:6]);
      line = {a[31:6], 6'b0};
      hw   = -1;
      for (int i = 0; i < 4; i++) if (m_st[idx][i] != 0 && m_tag[idx][i] == a[31:12]) hw = i;
      e_rv = 1; e_hit = 0; e_miss = 0; e_op = 0; e_sr = 0; e_wb = 0; e_l1 = 0; e_err = 0;
      case (c)
         4'd0, 4'd1, 4'd2: begin
            e_l1 = (c == 1) ? 4'b0001 : 4'b0010;
            if (hw >= 0) begin
               e_hit = 1;
               if (c == 1) begin
                  if (m_st[idx][hw] == 1) begin e_op = 3; e_baddr = line; end
                  m_st[idx][hw] = 3;
               end
               touch(idx, hw);
            end else begin
               e_miss = 1;
               w = -1;
               for (int i = 3; i >= 0; i--) if (m_st[idx][i] == 0) w = i;
               if (w < 0) begin
                  w = !b0[idx] ? (b1[idx] ? 1 : 0) : (b2[idx] ? 3 : 2);
                  e_l1 |= 4'b1000;
                  if (m_st[idx][w] == 3) begin
                     e_wb = 1;
                     e_wbaddr = {m_tag[idx][w], a[11:6], 6'b0};
                  end
               end
               m_tag[idx][w] = a[31:12];
               m_st[idx][w]  = (c == 1) ? 3 : (s >= 2 ? 2 : 1);
               e_op    = (c == 1) ? 4 : 1;
               e_baddr = line;
               touch(idx, w);
            end
         end
         4'd3, 4'd5: begin
            if (hw < 0) e_sr = 2;
            else begin
               if (m_st[idx][hw] == 3) begin
                  e_sr = 1; e_op = 2; e_baddr = line; e_l1 = 4'b0001;
               end
               if (c == 5) e_l1 |= 4'b0100;
               m_st[idx][hw] = (c == 3) ? 1 : 0;
            end
         end
         4'd4: e_sr = 2;
         4'd6: begin
            if (hw >= 0 && m_st[idx][hw] == 1) begin
               e_l1 = 4'b0100;
               m_st[idx][hw] = 0;
            end else e_sr = 2;
         end
         4'd8: begin
            model_clear();
            e_baddr = 0;
            e_wbaddr = 0;
         end
         4'd9: ;
         default: e_err = 1;
      endcase
      command = c; address = a; snoop_in = s; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      check_all($sformatf("cmd%0d@%h", c, a));
   endtask

   task automatic idle();
      cmd_valid = 1'b0;
      e_rv = 0; e_hit = 0; e_miss = 0; e_op = 0; e_sr = 0; e_wb = 0; e_l1 = 0; e_err = 0;
      @(posedge clk);
      #1;
      check_all("idle");
   endtask

   initial begin
      logic [3:0] cmd_tab [16];
      logic [3:0] c;
      logic [31:0] a;
      cmd_tab = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd0, 4'd1, 4'd3, 4'd3, 4'd4,
                  4'd5, 4'd6, 4'd6, 4'd7, 4'd9, 4'd13};
      rst_n = 1'b0; cmd_valid = 1'b0; command = '0; address = '0; snoop_in = 2'd2;
      model_clear();
      e_baddr = 0; e_wbaddr = 0;
      repeat (3) @(posedge clk);
      #1;
      e_rv = 0; e_hit = 0; e_miss = 0; e_op = 0; e_sr = 0; e_wb = 0; e_l1 = 0; e_err = 0;
      check_all("reset");
      rst_n = 1'b1;
      idle();

      step(4'd0, 32'h0000_1000, 2'd2);
      chk("tp_read_miss", 32'(miss), 1);
      chk("tp_read_op", 32'(bus_op), 1);
      chk("tp_read_addr", bus_addr, 32'h1000);
      step(4'd0, 32'h0000_1000, 2'd2);
      chk("tp_read_hit", 32'(hit), 1);
      step(4'd1, 32'h0000_1000, 2'd2);
      chk("tp_write_e_op", 32'(bus_op), 0);
      step(4'd3, 32'h0000_1000, 2'd2);
      chk("tp_snoop_hitm", 32'(snoop_resp), 1);
      chk("tp_snoop_wb", 32'(bus_op), 2);
      step(4'd1, 32'h0000_1000, 2'd2);
      chk("tp_write_s_inv", 32'(bus_op), 3);
      idle();

      step(4'd8, 32'h0, 2'd2);
      for (int t = 0; t < 4; t++) step(4'd1, 32'(t) << 12, 2'd2);
      step(4'd0, 32'h0000_4000, 2'd2);
      chk("tp_evict_wb", 32'(wb_valid), 1);
      chk("tp_evict_addr", wb_addr, 32'h0);
      chk("tp_evict_l1", 32'(l1_msg), 32'hA);
      chk("tp_evict_op", 32'(bus_op), 1);

      step(4'd0, 32'h0000_5040, 2'd0);
      step(4'd5, 32'h0000_5040, 2'd2);
      chk("tp_rwim_s", 32'(snoop_resp), 0);
      step(4'd0, 32'h0000_5040, 2'd2);
      chk("tp_after_rwim", 32'(miss), 1);
      step(4'd7, 32'h0000_5040, 2'd2);
      chk("tp_err7", 32'(err), 1);
      step(4'd12, 32'h0000_5040, 2'd2);
      chk("tp_err12", 32'(err), 1);
      step(4'd0, 32'h0000_5040, 2'd2);
      chk("tp_err_nochange", 32'(hit), 1);
      step(4'd8, 32'h0, 2'd2);
      step(4'd0, 32'h0000_1000, 2'd2);
      chk("tp_flush_miss", 32'(miss), 1);
      step(4'd3, 32'h0000_9980, 2'd2);
      chk("tp_absent_snoop", 32'(snoop_resp), 2);
      chk("tp_absent_op", 32'(bus_op), 0);

      for (int n = 0; n < 1500; n++) begin
         c = ($urandom_range(0, 199) == 0) ? 4'd8 : cmd_tab[$urandom_range(0, 15)];
         a = {20'($urandom_range(0, 5)), 6'($urandom_range(0, 2)), 6'($urandom_range(0, 63))};
         if ($urandom_range(0, 9) == 0) idle();
         step(c, a, 2'($urandom_range(0, 3)));
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cache.md
Name: cache

Overview:
- Last-level cache (LLC) tag/state model with MESI coherence and 4-way tree pseudo-LRU replacement.
- Sits between the L1 and the shared bus, driven one trace command per transaction.
- Decodes a 4-bit command plus 32-bit address and updates tag/MESI/PLRU state.
- Reports, each transaction: hit/miss, the issued bus operation, the snoop response, write-back on eviction, and L1 (inclusivity) messages.

Parameters:
- SETS, 64, number of sets (power of 2); index width IW = log2(SETS).
- WAYS, 4, associativity; fixed at 4 (3-bit PLRU tree).
- LINE_BYTES, 64, line size; offset width OW = 6.
- ADDR_W, 32, address width; tag width TW = ADDR_W-IW-OW.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present this cycle.
- command  in  4  trace command code.
- address  in  32  byte address.
- snoop_in  in  2  other caches' snoop result for our bus op: 0 HIT, 1 HITM, 2/3 NOHIT.
- resp_valid  out  1  registered response strobe.
- hit  out  1  lookup hit.
- miss  out  1  lookup miss.
- bus_op  out  3  0 none, 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM.
- bus_addr  out  32  line-aligned address of bus_op.
- snoop_resp  out  2  our reply to a snooped op: 0 HIT, 1 HITM, 2 NOHIT.
- wb_valid  out  1  dirty victim written back.
- wb_addr  out  32  line-aligned victim address.
- l1_msg  out  4  one-hot {EVICTLINE, INVALIDATELINE, SENDLINE, GETLINE}.
- err  out  1  invalid command.

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset: all lines I, PLRU bits 0, every output 0, counters 0.
- Address split: offset [5:0], index [OW+IW-1:OW], tag above.
- Latency: accepted with cmd_valid high on a clk edge; outputs registered and valid for exactly one cycle after (resp_valid=1). With no command, all outputs 0 except addresses, which hold.
- Back-to-back: one command per cycle, no stall.
- Read, codes 0 (data) and 2 (instruction):
  - Hit: state unchanged, l1_msg=SENDLINE.
  - Miss: allocate, bus_op=READ; snoop_in HIT/HITM gives S, NOHIT gives E; l1_msg=SENDLINE.
- Write, code 1:
  - Hit in M: stays M.
  - Hit in E: goes M, no bus op.
  - Hit in S: bus_op=INVALIDATE, goes M.
  - Miss: allocate, bus_op=RWIM, goes M.
  - l1_msg=GETLINE in all cases.
- Snooped ops: no hit/miss strobe and no PLRU update; snoop_resp NOHIT if line absent or I.
  - Code 3, snooped read: M gives HITM, bus_op=WRITE of the line, l1_msg=GETLINE, goes S. E/S give HIT, go S.
  - Code 4, snooped write: no state change, snoop_resp=NOHIT.
  - Code 5, snooped RWIM: M gives HITM, bus_op=WRITE, l1_msg=GETLINE|INVALIDATELINE, goes I. E/S give HIT, l1_msg=INVALIDATELINE, go I.
  - Code 6, snooped invalidate: S gives HIT, l1_msg=INVALIDATELINE, goes I. M/E are unchanged.
- Code 8: clear all lines to I, PLRU to 0, counters to 0; same effect as reset except the response strobe.
- Code 9: no state change, resp_valid only.
- Codes 7 and 10-15: err=1, no state change.
- Allocation: lowest-index invalid way first. Otherwise the PLRU victim:
  - b0=0: way (b1?1:0).
  - b0=1: way (b2?3:2).
- Victim eviction:
  - Always: l1_msg EVICTLINE.
  - If the victim is M: wb_valid=1, wb_addr = victim line address.
  - The miss bus_op is still issued in the same response.
- PLRU update on every L1 access (hit or fill) to way w:
  - w<2: b0=1, b1=(w==0).
  - Otherwise: b0=0, b2=(w==2).
- Same index hit and fill across consecutive cycles: the second command sees the first's updated state.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined: adds outputs stat_reads, stat_writes, stat_hits, stat_misses (32 bits each, saturating), updated on codes 0/2, 1, hit, miss. Cleared by reset and code 8.
- When undefined: the ports and counters are absent.

Test Plan:
- Reset, read 0x0000_1000, snoop_in=NOHIT -> miss=1, bus_op=READ, bus_addr=0x1000, line E; repeat the read -> hit=1, bus_op=0.
- Write 0x1000 (E) -> hit, bus_op=0, line M; snooped read 0x1000 -> snoop_resp=HITM, bus_op=WRITE, line S; write again -> bus_op=INVALIDATE.
- Fill 4 ways of set 0 (tags 0-3), all written to M, then read a 5th tag -> victim = way 0, wb_valid=1 with its address, l1_msg EVICTLINE, bus_op=READ.
- Snooped RWIM to an S line -> snoop_resp=HIT, line I; subsequent read -> miss.
- Command 7 and command 12 -> err=1, no state change; command 8 after fills -> all reads miss.
- Snooped read to an absent address -> snoop_resp=NOHIT, bus_op=0.
